// File: rtl/mem_data_port.sv
// Memory-side datapath stage: MAR/MDR registers and a req/ack memory transaction FSM
// with bounded wait, one-cycle completion pulse and sticky error flag.
module mem_data_port #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] BUS_data,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] MDR_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic              done_q, err_q;

  logic in_idle, start_rd, start_wr, illegal, acked, timeout_hit;

  assign in_idle     = (state_q == IDLE);
  assign start_rd    = in_idle && Read && !Write;
  assign start_wr    = in_idle && Write && !Read;
  assign illegal     = in_idle && Read && Write;
  assign acked       = !in_idle && mem_ack;
  assign timeout_hit = !in_idle && !mem_ack && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_rd)      state_d = RD;
        else if (start_wr) state_d = WR;
      end
      RD, WR: begin
        if (acked || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      RD:      mem_req = 1'b1;
      WR:      begin mem_req = 1'b1; mem_we = 1'b1; end
      default: ;
    endcase
  end

  // MAR/MDR only move in IDLE, except the read-data capture on ack
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt_q  <= '0;
      mar_q  <= '0;
      mdr_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= acked;
      if (in_idle) begin
        if (MARin) mar_q <= BUS_data[ADDR_W-1:0];
        if (MDRin) mdr_q <= BUS_data;
        if (start_rd || start_wr) begin
          cnt_q <= '0;
          err_q <= 1'b0;
        end else if (illegal) begin
          err_q <= 1'b1;
        end
      end else if (acked) begin
        if (state_q == RD) mdr_q <= mem_rdata;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign busy      = mem_req;
  assign done      = done_q;
  assign err       = err_q;
  assign MDR_out   = mdr_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;

endmodule
